mesh_term_rx: RTL and testbench

Terminal receive interface for one external port of the `mesh_gnrtr` router mesh. It drains packets from the router's terminal output port over the `pndng`/`data_out`/`pop` handshake and checks each packet's destination against its own terminal coordinates. Accepted packets are buffered with the header stripped and offered to local logic over a valid/ready interface. Misrouted packets are dropped and counted. One instance sits on each of the `2*ROWS + 2*COLUMS` mesh terminals, opposite the terminal's transmit FIFO.

---
 rtl/mesh_term_rx.sv | 141 ++++++++++++++
 tb/tb_mesh_term_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_term_rx.sv
// mesh_term_rx: receive side of one mesh terminal. Pops packets from the router, keeps the ones
// addressed to this terminal (or broadcast) and offers them to local logic over valid/ready.
module mesh_term_rx #(
    parameter int unsigned pckg_sz    = 40,
    parameter int unsigned fifo_depth = 4,
    parameter logic [3:0]  self_row   = 4'd1,
    parameter logic [3:0]  self_col   = 4'd0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pndng,
    input  logic [pckg_sz-1:0]  data_out,
    output logic                pop,
    output logic [pckg_sz-18:0] rx_payload,
    output logic                rx_mode,
    output logic                rx_bcst,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [15:0]         rx_cnt,
    output logic [15:0]         drop_cnt
);

    localparam int unsigned PayW = pckg_sz - 17;
    localparam int unsigned EntW = PayW + 2;
    localparam int unsigned PtrW = $clog2(fifo_depth);
    localparam int unsigned CntW = $clog2(fifo_depth) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StSettle
    } state_t;

    state_t            r_state;
    logic              r_pop;
    logic [15:0]       r_rx_cnt;
    logic [15:0]       r_drop_cnt;
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CntW-1:0]   r_count;
    logic [EntW-1:0]   r_mem [0:fifo_depth-1];

    logic [3:0]        w_row;
    logic [3:0]        w_col;
    logic              w_bcst;
    logic              w_accept;
    logic              w_space;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [EntW-1:0]   w_entry;
    logic [EntW-1:0]   w_head;
    logic              w_unused_jump;

    // Packet classification on the show-ahead head; only meaningful during StPop.
    assign w_row    = data_out[pckg_sz-9 -: 4];
    assign w_col    = data_out[pckg_sz-13 -: 4];
    assign w_bcst   = (w_row == 4'hF) && (w_col == 4'hF);
    assign w_accept = w_bcst || ((w_row == self_row) && (w_col == self_col));
    assign w_entry  = {w_bcst, data_out[pckg_sz-17], data_out[PayW-1:0]};

    // The next-jump byte is routing state for the mesh and has no meaning at the terminal.
    assign w_unused_jump = ^data_out[pckg_sz-1 -: 8];

    assign w_space  = (r_count < CntW'(fifo_depth));
    assign w_wr_en  = (r_state == StPop) && w_accept;
    assign w_rd_en  = rx_valid && rx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_pop      <= 1'b0;
            r_rx_cnt   <= 16'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (pndng && w_space) begin
                        r_state <= StPop;
                        r_pop   <= 1'b1;
                    end
                end
                StPop: begin
                    r_state <= StSettle;
                    r_pop   <= 1'b0;
                    if (w_accept) begin
                        if (r_rx_cnt != 16'hFFFF) r_rx_cnt <= r_rx_cnt + 16'd1;
                    end else begin
                        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
                    end
                end
                StSettle: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_pop   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= (r_wr_ptr == PtrW'(fifo_depth - 1)) ? '0 : r_wr_ptr + PtrW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= (r_rd_ptr == PtrW'(fifo_depth - 1)) ? '0 : r_rd_ptr + PtrW'(1);
            end
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_wr_en && w_rd_en) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign rx_valid   = (r_count != '0);
    assign rx_payload = rx_valid ? w_head[PayW-1:0] : '0;
    assign rx_mode    = rx_valid & w_head[PayW];
    assign rx_bcst    = rx_valid & w_head[PayW+1];
    assign pop        = r_pop;
    assign rx_cnt     = r_rx_cnt;
    assign drop_cnt   = r_drop_cnt;

    a_pop_spacing: assert property (@(posedge clk) disable iff (!reset) pop |=> !pop);
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) w_wr_en |-> w_space);

endmodule

// File: tb/tb_mesh_term_rx.sv
// tb_mesh_term_rx: randomized bench for mesh_term_rx against a packet-level reference model
// of the router queue, the receive buffer and the drop/accept counters.
module tb_mesh_term_rx;

    localparam int unsigned PckgSz = 40;
    localparam int unsigned Depth  = 4;
    localparam int unsigned PayW   = PckgSz - 17;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              pndng    = 1'b0;
    logic [PckgSz-1:0] data_out = '0;
    logic              rx_ready = 1'b0;
    logic              pop;
    logic [PayW-1:0]   rx_payload;
    logic              rx_mode;
    logic              rx_bcst;
    logic              rx_valid;
    logic [15:0]       rx_cnt;
    logic [15:0]       drop_cnt;

    mesh_term_rx #(
        .pckg_sz   (PckgSz),
        .fifo_depth(Depth),
        .self_row  (4'd1),
        .self_col  (4'd0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pndng     (pndng),
        .data_out  (data_out),
        .pop       (pop),
        .rx_payload(rx_payload),
        .rx_mode   (rx_mode),
        .rx_bcst   (rx_bcst),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_cnt    (rx_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PayW-1:0] pay;
        logic            mode;
        logic            bcst;
    } ent_t;

    logic [PckgSz-1:0] router_q[$];
    ent_t              exp_q[$];
    ent_t              log_q[$];
    logic [15:0]       exp_rx   = 16'd0;
    logic [15:0]       exp_drop = 16'd0;
    int                n_checks = 0;
    int                n_err    = 0;
    int                n_pops   = 0;
    logic              pp1        = 1'b0;
    logic              dec_ok     = 1'b0;
    logic              last_pop   = 1'b0;
    logic              last_valid = 1'b0;
    logic              rst_at_pop = 1'b0;
    logic              aborted    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PckgSz-1:0] mk(input logic [3:0] row, input logic [3:0] col,
                                             input logic mode, input logic [PayW-1:0] pay);
        return {8'h00, row, col, mode, pay};
    endfunction

    task automatic drive_router();
        pndng    = (router_q.size() != 0);
        data_out = pndng ? router_q[0] : '0;
    endtask

    // One clock cycle: check outputs at the negedge, advance the model over the next posedge,
    // then present the router side for that posedge.
    task automatic step(input logic rdy);
        logic              p;
        logic              rd;
        logic              acc;
        logic [3:0]        row;
        logic [3:0]        col;
        logic [PckgSz-1:0] pkt;
        ent_t              e;
        int                occ;
        @(negedge clk);
        rx_ready   = rdy;
        p          = pop;
        last_pop   = p;
        last_valid = rx_valid;
        if (!reset) begin
            chk("rst_pop", pop, 0);
            chk("rst_valid", rx_valid, 0);
            chk("rst_payload", rx_payload, 0);
            chk("rst_mode", rx_mode, 0);
            chk("rst_bcst", rx_bcst, 0);
            chk("rst_rx_cnt", rx_cnt, 0);
            chk("rst_drop_cnt", drop_cnt, 0);
            exp_q.delete();
            exp_rx   = 16'd0;
            exp_drop = 16'd0;
            pp1      = 1'b0;
            drive_router();
            dec_ok   = pndng;
            return;
        end
        chk("pop", p, dec_ok);
        chk("rx_valid", rx_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("rx_payload", rx_payload, exp_q[0].pay);
            chk("rx_mode", rx_mode, exp_q[0].mode);
            chk("rx_bcst", rx_bcst, exp_q[0].bcst);
        end
        chk("rx_cnt", rx_cnt, exp_rx);
        chk("drop_cnt", drop_cnt, exp_drop);
        if (p) n_pops++;
        if (p && rst_at_pop) begin
            reset = 1'b0;
            #1;
            chk("async_pop", pop, 0);
            chk("async_valid", rx_valid, 0);
            chk("async_rx_cnt", rx_cnt, 0);
            chk("async_drop_cnt", drop_cnt, 0);
            exp_q.delete();
            exp_rx     = 16'd0;
            exp_drop   = 16'd0;
            rst_at_pop = 1'b0;
            aborted    = 1'b1;
            pp1        = 1'b0;
            dec_ok     = 1'b0;
            return;
        end
        occ = exp_q.size();
        rd  = (occ != 0) && rdy;
        if (rd) begin
            e.pay  = rx_payload;
            e.mode = rx_mode;
            e.bcst = rx_bcst;
            log_q.push_back(e);
            void'(exp_q.pop_front());
        end
        if (p && router_q.size() != 0) begin
            // data_out must hold through the capturing edge; the router moves on next cycle.
            pkt    = router_q.pop_front();
            row    = pkt[PckgSz-9 -: 4];
            col    = pkt[PckgSz-13 -: 4];
            e.bcst = (row == 4'hF) && (col == 4'hF);
            acc    = e.bcst || (row == 4'd1 && col == 4'd0);
            if (acc) begin
                e.pay  = pkt[PayW-1:0];
                e.mode = pkt[PayW];
                exp_q.push_back(e);
                if (exp_rx != 16'hFFFF) exp_rx = exp_rx + 16'd1;
            end else begin
                if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
            end
        end else if (!p) begin
            drive_router();
        end
        dec_ok = !p && !pp1 && pndng && (occ < Depth);
        pp1    = p;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int                pstep;
        int                vstep;
        int                p0;
        int                sel;
        logic [7:0]        pat;
        logic [3:0]        row;
        logic [3:0]        col;
        logic [PckgSz-1:0] pkt;

        #1 reset = 1'b0;
        repeat (3) step(1'b1);
        reset = 1'b1;

        // Self-addressed packet and its one-cycle latency.
        log_q.delete();
        p0 = n_pops;
        pstep = -1;
        vstep = -1;
        router_q.push_back(mk(4'h1, 4'h0, 1'b1, 23'h00ABCD));
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            if (last_pop && pstep < 0) pstep = i;
            if (last_valid && vstep < 0) vstep = i;
        end
        chk("self_pops", n_pops - p0, 1);
        chk("self_latency", vstep, pstep + 1);
        chk("self_logged", log_q.size(), 1);
        if (log_q.size() > 0) begin
            chk("self_payload", log_q[0].pay, 23'h00ABCD);
            chk("self_mode", log_q[0].mode, 1);
            chk("self_bcst", log_q[0].bcst, 0);
        end
        chk("self_rx_cnt", rx_cnt, 1);

        // Misrouted packet.
        log_q.delete();
        p0 = n_pops;
        router_q.push_back(mk(4'h2, 4'h3, 1'b0, 23'h05A5A5));
        repeat (8) step(1'b1);
        chk("drop_pops", n_pops - p0, 1);
        chk("drop_logged", log_q.size(), 0);
        chk("drop_drop_cnt", drop_cnt, 1);
        chk("drop_rx_cnt", rx_cnt, 1);

        // Broadcast.
        log_q.delete();
        router_q.push_back(mk(4'hF, 4'hF, 1'b0, 23'h012345));
        repeat (8) step(1'b1);
        chk("bcst_logged", log_q.size(), 1);
        if (log_q.size() > 0) begin
            chk("bcst_payload", log_q[0].pay, 23'h012345);
            chk("bcst_flag", log_q[0].bcst, 1);
            chk("bcst_mode", log_q[0].mode, 0);
        end
        chk("bcst_rx_cnt", rx_cnt, 2);

        // Backpressure: six packets against a four-deep buffer.
        log_q.delete();
        p0 = n_pops;
        for (int i = 0; i < 6; i++) router_q.push_back(mk(4'h1, 4'h0, i[0], 23'h100 + 23'(i)));
        repeat (30) step(1'b0);
        chk("bp_pops_full", n_pops - p0, 4);
        chk("bp_valid", rx_valid, 1);
        chk("bp_pndng", pndng, 1);
        repeat (40) step(1'b1);
        chk("bp_pops_total", n_pops - p0, 6);
        chk("bp_logged", log_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_q.size()) chk("bp_order", log_q[i].pay, 23'h100 + 23'(i));
        end

        // Pop spacing with pndng held high by a stream of drops.
        for (int i = 0; i < 8; i++) router_q.push_back(mk(4'h2, 4'h3, 1'b0, 23'(i)));
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            pat[i] = last_pop;
        end
        chk("pop_pattern", pat, 8'b1001_0010);
        repeat (30) step(1'b1);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            if (router_q.size() < 6 && ($urandom % 3) == 0) begin
                sel = $urandom % 4;
                row = 4'($urandom);
                col = 4'($urandom);
                if (sel == 0) begin
                    row = 4'h1;
                    col = 4'h0;
                end else if (sel == 1) begin
                    row = 4'hF;
                    col = 4'hF;
                end else if (sel == 2) begin
                    row = 4'h1;
                    col = 4'h1 + 4'($urandom % 14);
                end
                pkt = mk(row, col, 1'($urandom), 23'($urandom));
                pkt[PckgSz-1 -: 8] = 8'($urandom);
                router_q.push_back(pkt);
            end
            step(($urandom % 4) != 0);
        end
        repeat (80) step(1'b1);
        chk("rand_router_empty", router_q.size(), 0);
        chk("rand_buffer_empty", exp_q.size(), 0);

        // Reset asserted during POP: packet is retained by the router and taken once later.
        log_q.delete();
        router_q.push_back(mk(4'h1, 4'h0, 1'b1, 23'h000777));
        rst_at_pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!aborted) step(1'b1);
        end
        rst_at_pop = 1'b0;
        chk("rst_hit_pop", aborted, 1);
        repeat (2) step(1'b1);
        reset = 1'b1;
        p0 = n_pops;
        repeat (10) step(1'b1);
        chk("rst_repops", n_pops - p0, 1);
        chk("rst_rx_cnt_after", rx_cnt, 1);
        chk("rst_logged", log_q.size(), 1);
        if (log_q.size() > 0) chk("rst_payload_after", log_q[0].pay, 23'h000777);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
